// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer: fetch-stage PC controller with imem handshake, stall handling,
// EX redirect priority and buffering of redirects behind an outstanding fetch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic        jalr_valid,
  input  logic [31:0] branch_target,
  input  logic [31:0] alu_result,
  input  logic [31:0] next_PC,
  input  logic        imem_ready,
  output logic [31:0] current_PC,
  output logic [1:0]  PCSrc,
  output logic        PCWrite,
  output logic        imem_req,
  output logic        if_valid,
  output logic        flush,
  output logic        redirect_pending
);

  localparam logic [1:0] S_HOLD  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_BR   = 2'b01;
  localparam logic [1:0] SRC_JALR = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic        pending_q, pending_d;

  logic        redir;
  logic [31:0] sel_target;
  logic [1:0]  sel_src;

  // jalr outranks a simultaneous branch
  assign redir      = jalr_valid | br_taken;
  assign sel_target = jalr_valid ? alu_result : branch_target;
  assign sel_src    = jalr_valid ? SRC_JALR : SRC_BR;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_HOLD;
      pc_q      <= RESET_PC;
      redir_q   <= 32'h0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      redir_q   <= redir_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    redir_d   = redir_q;
    pending_d = pending_q;
    case (state_q)
      S_HOLD: state_d = S_FETCH;
      S_FETCH: begin
        if (redir) begin
          if (imem_ready) begin
            pc_d = next_PC;
          end else begin
            redir_d   = sel_target;
            pending_d = 1'b1;
            state_d   = S_DRAIN;
          end
        end else if (!stall && imem_ready) begin
          pc_d = next_PC;
        end
      end
      S_DRAIN: begin
        if (redir) redir_d = sel_target;
        // The buffered target bypasses Fetch; a same-cycle redirect wins.
        if (imem_ready) begin
          pc_d      = redir ? sel_target : redir_q;
          pending_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_comb begin
    PCSrc    = SRC_SEQ;
    PCWrite  = 1'b0;
    imem_req = 1'b0;
    if_valid = 1'b0;
    flush    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redir) begin
          PCSrc    = sel_src;
          flush    = 1'b1;
          imem_req = 1'b1;
          PCWrite  = imem_ready;
        end else if (!stall) begin
          imem_req = 1'b1;
          PCWrite  = imem_ready;
          if_valid = imem_ready;
        end
      end
      S_DRAIN: begin
        imem_req = 1'b1;
        PCWrite  = imem_ready;
        if (redir) begin
          PCSrc = sel_src;
          flush = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign current_PC       = pc_q;
  assign redirect_pending = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken, jalr_valid, imem_ready;
  logic [31:0] branch_target, alu_result, next_PC, current_PC;
  logic [1:0]  PCSrc;
  logic        PCWrite, imem_req, if_valid, flush, redirect_pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Fetch block model: PC mux driven by PCSrc
  assign next_PC = (PCSrc == 2'b00) ? current_PC + 32'd4 :
                   (PCSrc == 2'b01) ? branch_target : alu_result;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
    .jalr_valid(jalr_valid), .branch_target(branch_target),
    .alu_result(alu_result), .next_PC(next_PC), .imem_ready(imem_ready),
    .current_PC(current_PC), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .imem_req(imem_req), .if_valid(if_valid), .flush(flush),
    .redirect_pending(redirect_pending)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) cycle();
    checks++;
    if (current_PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 00000000", current_PC); end
    checks++;
    if (redirect_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", redirect_pending); end
    reset = 1'b1;
    #1;
    checks++;
    if ({imem_req, PCWrite, flush, if_valid} !== 4'b0) begin errors++; $display("FAIL hold_outputs got %b want 0000", {imem_req, PCWrite, flush, if_valid}); end
    cycle();
    #1;
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req got %b want 1", imem_req); end
  endtask

  task automatic test_stream();
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({if_valid, PCWrite, PCSrc} !== 4'b1100) begin errors++; $display("FAIL stream_ctl[%0d] got %b want 1100", i, {if_valid, PCWrite, PCSrc}); end
      cycle();
      checks++;
      if (current_PC !== 32'd4 * (i + 1)) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, current_PC, 32'd4 * (i + 1)); end
    end
  endtask

  task automatic test_branch();
    br_taken = 1'b1; branch_target = 32'h40; imem_ready = 1'b1;
    #1;
    checks++;
    if ({PCSrc, flush, if_valid, PCWrite} !== 5'b01101) begin errors++; $display("FAIL branch_ctl got %b want 01101", {PCSrc, flush, if_valid, PCWrite}); end
    cycle();
    checks++;
    if (current_PC !== 32'h40) begin errors++; $display("FAIL branch_pc got %h want 00000040", current_PC); end
    jalr_valid = 1'b1; alu_result = 32'h200;
    #1;
    checks++;
    if (PCSrc !== 2'b10) begin errors++; $display("FAIL jalr_prio_src got %b want 10", PCSrc); end
    cycle();
    checks++;
    if (current_PC !== 32'h200) begin errors++; $display("FAIL jalr_prio_pc got %h want 00000200", current_PC); end
    br_taken = 1'b0; jalr_valid = 1'b0;
  endtask

  task automatic test_buffered();
    jalr_valid = 1'b1; alu_result = 32'h100; imem_ready = 1'b0;
    #1;
    checks++;
    if ({flush, imem_req, PCWrite} !== 3'b110) begin errors++; $display("FAIL buf_start got %b want 110", {flush, imem_req, PCWrite}); end
    cycle();
    jalr_valid = 1'b0; alu_result = 32'hDEAD_0000;
    for (int i = 0; i < 3; i++) begin
      imem_ready = (i == 2);
      #1;
      checks++;
      if ({redirect_pending, imem_req} !== 2'b11 || current_PC !== 32'h200) begin
        errors++; $display("FAIL drain[%0d] got pend/req %b pc %h want 11 pc 00000200", i, {redirect_pending, imem_req}, current_PC);
      end
      if (i == 2) begin
        checks++;
        if ({if_valid, PCWrite, PCSrc} !== 4'b0100) begin errors++; $display("FAIL drain_done_ctl got %b want 0100", {if_valid, PCWrite, PCSrc}); end
      end
      cycle();
    end
    checks++;
    if (current_PC !== 32'h100 || redirect_pending !== 1'b0) begin
      errors++; $display("FAIL buf_land got pc %h pend %b want 00000100 0", current_PC, redirect_pending);
    end
  endtask

  task automatic test_stall();
    br_taken = 1'b1; branch_target = 32'h10; imem_ready = 1'b1;
    cycle();
    br_taken = 1'b0; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({imem_req, PCWrite, if_valid} !== 3'b000) begin errors++; $display("FAIL stall_ctl[%0d] got %b want 000", i, {imem_req, PCWrite, if_valid}); end
      cycle();
      checks++;
      if (current_PC !== 32'h10) begin errors++; $display("FAIL stall_pc[%0d] got %h want 00000010", i, current_PC); end
    end
    br_taken = 1'b1; branch_target = 32'h80;
    #1;
    checks++;
    if ({PCSrc, flush, PCWrite} !== 4'b0111) begin errors++; $display("FAIL stall_redir_ctl got %b want 0111", {PCSrc, flush, PCWrite}); end
    cycle();
    checks++;
    if (current_PC !== 32'h80) begin errors++; $display("FAIL stall_redir_pc got %h want 00000080", current_PC); end
    br_taken = 1'b0; stall = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    jalr_valid = 1'b1; alu_result = 32'h300; imem_ready = 1'b0;
    cycle();
    jalr_valid = 1'b0;
    #1;
    checks++;
    if (redirect_pending !== 1'b1) begin errors++; $display("FAIL mid_drain_pend got %b want 1", redirect_pending); end
    reset = 1'b0;
    cycle();
    checks++;
    if (current_PC !== 32'h0 || redirect_pending !== 1'b0) begin
      errors++; $display("FAIL mid_drain_reset got pc %h pend %b want 00000000 0", current_PC, redirect_pending);
    end
    reset = 1'b1; imem_ready = 1'b1;
    #1;
    checks++;
    if ({imem_req, PCWrite} !== 2'b00) begin errors++; $display("FAIL late_ready_ctl got %b want 00", {imem_req, PCWrite}); end
    cycle();
    checks++;
    if (current_PC !== 32'h0) begin errors++; $display("FAIL late_ready_pc got %h want 00000000", current_PC); end
    imem_ready = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1) begin errors++; $display("FAIL post_reset_req got %b want 1", imem_req); end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; br_taken = 1'b0; jalr_valid = 1'b0;
    imem_ready = 1'b0; branch_target = 32'h0; alu_result = 32'h0;
    #1;
    test_reset();
    test_stream();
    test_branch();
    test_buffered();
    test_stall();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
